// File: rtl/shared_accum_scheduler.sv
// ============================================================================
// shared_accum_scheduler: round-robin arbiter serialising add/load updates onto
// one shared accumulator. Optional macro SCHED_PRIORITY_EN (requester 0 fixed
// top priority). Rev 1.0
// ============================================================================
`default_nettype none

module shared_accum_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          op_sel,
  input  logic [NUM_REQ*DATA_W-1:0]   count_in,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        done,
  output logic [2:0]                  done_id,
  output logic [DATA_W-1:0]           accum_out,
  output logic                        ovf,
  output logic [31:0]                 op_count,
  output logic                        busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                done_q, done_d;
  logic [2:0]          done_id_q, done_id_d;
  logic [DATA_W-1:0]   accum_q, accum_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         op_count_q, op_count_d;
  logic                busy_q, busy_d;

  logic                rr_found;
  logic [PTR_W-1:0]    rr_pick;
  logic [IDX_W-1:0]    scan_idx;
  logic                prio0;
  logic [DATA_W+1:0]   prod2, prod3;
  logic [DATA_W+2:0]   sum;

  // First set request scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (scan_idx >= IDX_W'(NUM_REQ)) begin
        scan_idx = scan_idx - IDX_W'(NUM_REQ);
      end
      if (!rr_found && req[scan_idx[PTR_W-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = scan_idx[PTR_W-1:0];
      end
    end
  end

`ifdef SCHED_PRIORITY_EN
  assign prio0 = req[0];
`else
  assign prio0 = 1'b0;
`endif

  assign prod2 = {1'b0, cnt_q, 1'b0};
  assign prod3 = {2'b00, cnt_q} + {1'b0, cnt_q, 1'b0};
  assign sum   = {3'b000, accum_q} + {1'b0, prod2};

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    accum_d    = accum_q;
    ovf_d      = ovf_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_EXEC;
          if (prio0) begin
            win_d = '0;
          end else begin
            win_d    = rr_pick;
            rr_ptr_d = (rr_pick == PTR_W'(NUM_REQ - 1)) ? '0 : rr_pick + 1'b1;
          end
          op_d  = op_sel[win_d];
          cnt_d = count_in[win_d*DATA_W +: DATA_W];
          gnt_d = NUM_REQ'(1) << win_d;
        end
      end
      S_EXEC: begin
        // Result lands together with the done pulse in the WB cycle.
        state_d    = S_WB;
        gnt_d      = '0;
        done_d     = 1'b1;
        done_id_d  = 3'(win_q);
        op_count_d = op_count_q + 32'd1;
        if (op_q) begin
          accum_d = prod3[DATA_W-1:0];
        end else begin
          accum_d = sum[DATA_W-1:0];
          ovf_d   = ovf_q | (|sum[DATA_W+2:DATA_W]);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      op_q       <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      accum_q    <= '0;
      ovf_q      <= 1'b0;
      op_count_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      accum_q    <= accum_d;
      ovf_q      <= ovf_d;
      op_count_q <= op_count_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign accum_out = accum_q;
  assign ovf       = ovf_q;
  assign op_count  = op_count_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_accum_scheduler.sv
// ============================================================================
// tb_shared_accum_scheduler: scoreboard bench with a transaction-level model
// of the shared accumulator scheduler. Rev 1.0
// ============================================================================
`default_nettype none

module tb_shared_accum_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  op_sel;
  logic [CW-1:0] count_in;
  logic [N-1:0]  gnt;
  logic          done;
  logic [2:0]    done_id;
  logic [W-1:0]  accum_out;
  logic          ovf;
  logic [31:0]   op_count;
  logic          busy;

  always #5 clk = ~clk;

  shared_accum_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op_sel   (op_sel),
    .count_in (count_in),
    .gnt      (gnt),
    .done     (done),
    .done_id  (done_id),
    .accum_out(accum_out),
    .ovf      (ovf),
    .op_count (op_count),
    .busy     (busy)
  );

  typedef struct {
    int           id;
    logic [N-1:0] gnt;
    int           acc;
    bit           ovf;
    int           opc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference state: the architectural view of the shared accumulator.
  int m_rr  = 0;
  int m_acc = 0;
  bit m_ovf = 0;
  int m_opc = 0;

  logic [N-1:0] seen_gnt = '0;
  time          last_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_issue(input logic [N-1:0] r, input logic [N-1:0] op,
                             input logic [CW-1:0] cnt, output exp_t e);
    int w;
    int c;
    int s;
    w = -1;
`ifdef SCHED_PRIORITY_EN
    if (r[0]) w = 0;
`endif
    if (w < 0) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && r[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
      m_rr = (w + 1) % N;
    end
    c = int'(cnt[w*W +: W]);
    if (op[w] == 1'b0) begin
      s = m_acc + 2 * c;
      if (s >= (1 << W)) m_ovf = 1'b1;
      m_acc = s % (1 << W);
    end else begin
      m_acc = (3 * c) % (1 << W);
    end
    m_opc++;
    e.id  = w;
    e.gnt = N'(1) << w;
    e.acc = m_acc;
    e.ovf = m_ovf;
    e.opc = m_opc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 10);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Called at a negedge with the DUT idle; inputs are scrambled right after
  // the sampling edge so the captured operands are the only ones that count.
  task automatic issue(input logic [N-1:0] r, input logic [N-1:0] op,
                       input logic [CW-1:0] cnt);
    exp_t e;
    req      = r;
    op_sel   = op;
    count_in = cnt;
    if (r != '0) begin
      model_issue(r, op, cnt, e);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req      = N'($urandom);
    op_sel   = N'($urandom);
    count_in = CW'($urandom);
    wait_idle();
  endtask

  task automatic single(input int idx, input bit op1, input int c);
    logic [N-1:0]  r;
    logic [N-1:0]  o;
    logic [CW-1:0] cv;
    r           = N'(1) << idx;
    o           = N'($urandom);
    o[idx]      = op1;
    cv          = CW'($urandom);
    cv[idx*W +: W] = W'(c);
    issue(r, o, cv);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) seen_gnt = gnt;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done_id %0d with nothing outstanding, expected no done", done_id);
        end else begin
          mon_e = sb.pop_front();
          chk("done_id",     32'(done_id),   32'(mon_e.id));
          chk("gnt_in_exec", 32'(seen_gnt),  32'(mon_e.gnt));
          chk("gnt_in_wb",   32'(gnt),       32'd0);
          chk("accum_out",   32'(accum_out), 32'(mon_e.acc));
          chk("ovf",         32'(ovf),       32'(mon_e.ovf));
          chk("op_count",    op_count,       32'(mon_e.opc));
          chk("busy_in_wb",  32'(busy),      32'd1);
          if (last_done != 0) chk("done_spacing_ge_3", 32'(($time - last_done) >= 30), 32'd1);
        end
        last_done = $time;
        seen_gnt  = '0;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    req      = '0;
    op_sel   = '0;
    count_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_gnt",      32'(gnt),       32'd0);
    chk("rst_done",     32'(done),      32'd0);
    chk("rst_done_id",  32'(done_id),   32'd0);
    chk("rst_accum",    32'(accum_out), 32'd0);
    chk("rst_ovf",      32'(ovf),       32'd0);
    chk("rst_op_count", op_count,       32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    @(negedge clk);

    single(0, 1'b0, 5);                          // accum = 10
    for (int i = 0; i < 5; i++) issue(4'b1111, N'($urandom), CW'($urandom));

    // Overflow path: 150 -> 250 -> 260 wraps to 4 with ovf -> load 300 -> 44.
    single(0, 1'b1, 50);
    single(1, 1'b0, 50);
    single(2, 1'b0, 5);
    single(3, 1'b1, 100);

    // Abort an operation in EXEC with an asynchronous reset.
    req      = 4'b0010;
    op_sel   = 4'b0000;
    count_in = CW'(32'h0000_7700);
    @(posedge clk);
    #2;
    rst = 1'b1;
    req = '0;
    #1;
    chk("abort_gnt",      32'(gnt),       32'd0);
    chk("abort_done",     32'(done),      32'd0);
    chk("abort_accum",    32'(accum_out), 32'd0);
    chk("abort_ovf",      32'(ovf),       32'd0);
    chk("abort_op_count", op_count,       32'd0);
    chk("abort_busy",     32'(busy),      32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_rr  = 0;
    m_acc = 0;
    m_ovf = 1'b0;
    m_opc = 0;
    repeat (3) @(negedge clk);

    // Requester 2 is served (operands scrambled after grant), then wrap from rr_ptr=3.
    single(2, 1'b0, 33);
    issue(4'b0011, N'($urandom), CW'($urandom));
    issue(4'b1111, N'($urandom), CW'($urandom));

    for (int i = 0; i < 150; i++) begin
      issue(N'($urandom), N'($urandom), CW'($urandom));
    end

    req = '0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shared_accum_scheduler.md
# shared_accum_scheduler

Round-robin scheduler that shares a single DATA_W-bit accumulator register between NUM_REQ requesters. Each requester asks for either an add-scaled update (accum += count*2) or a load-scaled update (accum = count*3). The block serialises these requests through a three-state FSM and returns a per-operation completion pulse. It sits in front of the shared register/counter datapath and is its only writer.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- DATA_W, 8: accumulator and count width, 4..16

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request, level; held until matching done
- op_sel  input  NUM_REQ  per-requester op: 0 = add count*2, 1 = load count*3
- count_in  input  NUM_REQ*DATA_W  flattened operands; requester i at [i*DATA_W +: DATA_W]
- gnt  output  NUM_REQ  one-hot grant, high only in EXEC
- done  output  1  one-cycle completion pulse
- done_id  output  3  index of the completed requester; valid with done
- accum_out  output  DATA_W  accumulator value
- ovf  output  1  sticky carry-out flag for add operations
- op_count  output  32  total completed operations, wraps at 2^32
- busy  output  1  high when the FSM is not in IDLE

## Operation
- Reset values: state IDLE, gnt 0, done 0, done_id 0, accum_out 0, ovf 0, op_count 0, busy 0, rr_ptr 0.
- FSM states: IDLE, EXEC, WB.
  - IDLE -> EXEC when any req bit is set. The winner is the first set bit scanning upward from rr_ptr, mod NUM_REQ. On entry, register gnt, the winner index, op_sel[winner] and count_in[winner]. Set rr_ptr = (winner+1) mod NUM_REQ.
  - EXEC -> WB unconditionally. Compute the result from the captured operands only.
  - WB -> IDLE unconditionally. Write accum_out, pulse done with done_id, increment op_count, clear gnt.
- Arithmetic:
  - Products are formed at DATA_W+2 bits.
  - op 0: sum = accum_out + count*2 at DATA_W+3 bits. accum_out takes the low DATA_W bits. Set ovf if any higher bit is nonzero.
  - op 1: accum_out = low DATA_W bits of count*3. ovf is unchanged.
- Requests are sampled only in IDLE. A requester may drop or change req, op_sel or count_in after the grant; the captured operation still completes.
- A requester that keeps req asserted after its done is treated as a new request. Under round-robin it is served again only after every other pending requester.
- ovf clears only on reset.
- Reset mid-operation aborts it: no done pulse, accum_out returns to 0.

## Timing
- Edge n: IDLE with req != 0. Edge n+1: EXEC, gnt valid. Edge n+2: WB, done=1, accum_out updated. Edge n+3: IDLE.
- Latency from request sampled to done: 2 cycles. Throughput: 1 operation per 3 cycles. A request pending during WB is sampled at the following IDLE.
- All outputs are registered; no combinational path from input to output.
- busy is high in EXEC and WB.

## Configuration
- SCHED_PRIORITY_EN:
  - Defined: requester 0 has fixed top priority. If req[0] is set in IDLE, it wins regardless of rr_ptr, and rr_ptr is not updated. Other requesters use round-robin among themselves.
  - Undefined: pure round-robin across all requesters, as described above.

## Test plan
- Reset, then req=4'b0001, op_sel=0, count=8'd5 -> gnt=0001 one cycle later, done with done_id=0 two cycles after sampling, accum_out=10, op_count=1.
- req=4'b1111 held continuously from reset -> done_id sequence 0,1,2,3,0 at a 3-cycle spacing (SCHED_PRIORITY_EN undefined). With SCHED_PRIORITY_EN defined, the sequence is 0,0,0…
- accum=250 (loaded via op1 count... or via adds), then op0 count=8'd5 -> accum_out=4 (260 mod 256), ovf=1. A following op1 count=8'd100 -> accum_out=44 (300 mod 256), ovf stays 1.
- Requester 2 drops req and changes count_in in the cycle after its grant -> operation completes with the captured operands, done_id=2.
- Assert rst in EXEC -> next cycle: state IDLE, gnt=0, accum_out=0, ovf=0, op_count=0, and no done pulse.
- NUM_REQ=3, rr_ptr=2, req=3'b011 -> requester 0 wins, rr_ptr becomes 1.
